// File: rtl/h264_mb_feed_sequencer.sv
// Macroblock feed sequencer: routes the upstream word stream to the luma and chroma ports of the
// H.264 core, one MB at a time. Optional macro H264SEQ_STATS_EN adds the frame_cycles counter.
module h264_mb_feed_sequencer #(
    parameter int unsigned MB_WIDTH   = 11,
    parameter int unsigned MB_HEIGHT  = 9,
    parameter int unsigned LUMA_WORDS = 64,
    parameter int unsigned CHROMA_WDS = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [5:0]  QP_IN,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        NEWSLICE,
    output logic        NEWLINE,
    output logic [5:0]  QP,
    input  logic        intra4x4_READYI,
    output logic        intra4x4_STROBEI,
    output logic [31:0] intra4x4_DATAI,
    input  logic        intra8x8cc_readyi,
    output logic        intra8x8cc_strobei,
    output logic [31:0] intra8x8cc_datai,
    input  logic        xbuffer_DONE,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [7:0]  mb_x,
`ifdef H264SEQ_STATS_EN
    output logic [31:0] frame_cycles,
`endif
    output logic [7:0]  mb_y
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LUMA   = 2'd1;
    localparam logic [1:0] ST_CHROMA = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    localparam logic [6:0] LUMA_LIM    = 7'(LUMA_WORDS);
    localparam logic [6:0] LUMA_LAST   = 7'(LUMA_WORDS - 1);
    localparam logic [5:0] CHROMA_LIM  = 6'(CHROMA_WDS);
    localparam logic [5:0] CHROMA_LAST = 6'(CHROMA_WDS - 1);
    localparam logic [7:0] X_LAST      = 8'(MB_WIDTH - 1);
    localparam logic [7:0] Y_LAST      = 8'(MB_HEIGHT - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_luma_cnt;
    logic [5:0]  r_chroma_cnt;
    logic [7:0]  r_mb_x;
    logic [7:0]  r_mb_y;
    logic [5:0]  r_qp;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_newline;
    logic        r_newslice;
    logic        r_luma_stb;
    logic [31:0] r_luma_data;
    logic        r_chroma_stb;
    logic [31:0] r_chroma_data;

    logic        w_src_ready;
    logic        w_accept;
    logic        w_start;

    always_comb begin
        w_src_ready = 1'b0;
        case (r_state)
            ST_LUMA:   w_src_ready = intra4x4_READYI && (r_luma_cnt < LUMA_LIM);
            ST_CHROMA: w_src_ready = intra8x8cc_readyi && (r_chroma_cnt < CHROMA_LIM);
            default:   w_src_ready = 1'b0;
        endcase
    end

    assign w_accept = src_valid && w_src_ready;
    // BUSY stays high through the FRAME_DONE cycle, so a START there is dropped.
    assign w_start  = START && (r_state == ST_IDLE) && !r_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_luma_cnt    <= '0;
            r_chroma_cnt  <= '0;
            r_mb_x        <= '0;
            r_mb_y        <= '0;
            r_qp          <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_newline     <= 1'b0;
            r_newslice    <= 1'b0;
            r_luma_stb    <= 1'b0;
            r_luma_data   <= '0;
            r_chroma_stb  <= 1'b0;
            r_chroma_data <= '0;
        end else begin
            r_luma_stb   <= w_accept && (r_state == ST_LUMA);
            r_chroma_stb <= w_accept && (r_state == ST_CHROMA);
            if (w_accept && (r_state == ST_LUMA)) begin
                r_luma_data <= src_data;
            end
            if (w_accept && (r_state == ST_CHROMA)) begin
                r_chroma_data <= src_data;
            end
            r_frame_done <= 1'b0;
            if (r_frame_done) begin
                r_busy <= 1'b0;
            end
            // Row/slice markers drop after the cycle carrying the first luma strobe.
            if (r_luma_stb) begin
                r_newline  <= 1'b0;
                r_newslice <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_qp         <= QP_IN;
                        r_mb_x       <= '0;
                        r_mb_y       <= '0;
                        r_busy       <= 1'b1;
                        r_luma_cnt   <= '0;
                        r_chroma_cnt <= '0;
                        r_newline    <= 1'b1;
                        r_newslice   <= 1'b1;
                        r_state      <= ST_LUMA;
                    end
                end
                ST_LUMA: begin
                    if (w_accept) begin
                        r_luma_cnt <= r_luma_cnt + 7'd1;
                        if (r_luma_cnt == LUMA_LAST) begin
                            r_state <= ST_CHROMA;
                        end
                    end
                end
                ST_CHROMA: begin
                    if (w_accept) begin
                        r_chroma_cnt <= r_chroma_cnt + 6'd1;
                        if (r_chroma_cnt == CHROMA_LAST) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (xbuffer_DONE) begin
                        r_luma_cnt   <= '0;
                        r_chroma_cnt <= '0;
                        if ((r_mb_x == X_LAST) && (r_mb_y == Y_LAST)) begin
                            r_mb_x       <= '0;
                            r_mb_y       <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else if (r_mb_x == X_LAST) begin
                            r_mb_x    <= '0;
                            r_mb_y    <= r_mb_y + 8'd1;
                            r_newline <= 1'b1;
                            r_state   <= ST_LUMA;
                        end else begin
                            r_mb_x  <= r_mb_x + 8'd1;
                            r_state <= ST_LUMA;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef H264SEQ_STATS_EN
    logic [31:0] r_frame_cycles;

    // The START cycle counts as 1; counting continues while BUSY, which covers FRAME_DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_cycles <= '0;
        end else if (w_start) begin
            r_frame_cycles <= 32'd1;
        end else if (r_busy) begin
            r_frame_cycles <= r_frame_cycles + 32'd1;
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

    assign src_ready          = w_src_ready;
    assign NEWSLICE           = r_newslice;
    assign NEWLINE            = r_newline;
    assign QP                 = r_qp;
    assign intra4x4_STROBEI   = r_luma_stb;
    assign intra4x4_DATAI     = r_luma_data;
    assign intra8x8cc_strobei = r_chroma_stb;
    assign intra8x8cc_datai   = r_chroma_data;
    assign BUSY               = r_busy;
    assign FRAME_DONE         = r_frame_done;
    assign mb_x               = r_mb_x;
    assign mb_y               = r_mb_y;

endmodule

// File: tb/tb_h264_mb_feed_sequencer.sv
// Directed bench for h264_mb_feed_sequencer on a 2x2-MB frame; source words are an incrementing
// count so luma/chroma routing and ordering can be checked per strobe.
module tb_h264_mb_feed_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [5:0]  QP_IN;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        NEWSLICE;
    logic        NEWLINE;
    logic [5:0]  QP;
    logic        intra4x4_READYI;
    logic        intra4x4_STROBEI;
    logic [31:0] intra4x4_DATAI;
    logic        intra8x8cc_readyi;
    logic        intra8x8cc_strobei;
    logic [31:0] intra8x8cc_datai;
    logic        xbuffer_DONE;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [7:0]  mb_x;
    logic [7:0]  mb_y;
`ifdef H264SEQ_STATS_EN
    logic [31:0] frame_cycles;
`endif

    always #5 CLK = ~CLK;

    h264_mb_feed_sequencer #(
        .MB_WIDTH   (2),
        .MB_HEIGHT  (2),
        .LUMA_WORDS (64),
        .CHROMA_WDS (32)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .START              (START),
        .QP_IN              (QP_IN),
        .src_data           (src_data),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .NEWSLICE           (NEWSLICE),
        .NEWLINE            (NEWLINE),
        .QP                 (QP),
        .intra4x4_READYI    (intra4x4_READYI),
        .intra4x4_STROBEI   (intra4x4_STROBEI),
        .intra4x4_DATAI     (intra4x4_DATAI),
        .intra8x8cc_readyi  (intra8x8cc_readyi),
        .intra8x8cc_strobei (intra8x8cc_strobei),
        .intra8x8cc_datai   (intra8x8cc_datai),
        .xbuffer_DONE       (xbuffer_DONE),
        .BUSY               (BUSY),
        .FRAME_DONE         (FRAME_DONE),
        .mb_x               (mb_x),
`ifdef H264SEQ_STATS_EN
        .frame_cycles       (frame_cycles),
`endif
        .mb_y               (mb_y)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_luma, n_chroma, order_errs, stb_errs, qp_errs, n_fd, ns_stb, nl_stb;
    int fd_cyc, start_cyc, done_dly;
    logic [31:0] exp_word;
    logic [5:0]  exp_qp;
    logic        prev_acc;
    bit          auto_done, rand_valid, tog_mode;

    // One clock: observe at mid-cycle, then step to just after the next rising edge.
    task automatic tick();
        #3;
        if (intra4x4_STROBEI) begin
            n_luma++;
            if (!prev_acc) stb_errs++;
            if (intra4x4_DATAI !== exp_word || (exp_word % 96) >= 64) order_errs++;
            exp_word++;
            if (NEWSLICE) ns_stb++;
            if (NEWLINE) nl_stb++;
        end
        if (intra8x8cc_strobei) begin
            n_chroma++;
            if (!prev_acc) stb_errs++;
            if (intra8x8cc_datai !== exp_word || (exp_word % 96) < 64) order_errs++;
            exp_word++;
            if (auto_done && (n_chroma % 32) == 0) done_dly = 5;
        end
        if (BUSY && QP !== exp_qp) qp_errs++;
        if (FRAME_DONE) begin
            n_fd++;
            fd_cyc = cyc;
        end
        prev_acc = src_valid && src_ready;
        cyc++;
        @(posedge CLK);
        #1;
        if (prev_acc) src_data = src_data + 1;
        src_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tog_mode && (cyc % 3) == 0) intra4x4_READYI = !intra4x4_READYI;
        xbuffer_DONE = 1'b0;
        if (done_dly > 0) begin
            done_dly--;
            if (done_dly == 0) xbuffer_DONE = 1'b1;
        end
    endtask

    task automatic start_frame(input logic [5:0] qp);
        src_data = 0;
        exp_word = 0;
        prev_acc = 1'b0;
        n_luma = 0; n_chroma = 0; order_errs = 0; stb_errs = 0; qp_errs = 0;
        n_fd = 0; ns_stb = 0; nl_stb = 0; done_dly = 0;
        exp_qp = qp;
        QP_IN = qp;
        START = 1'b1;
        start_cyc = cyc;
        tick();
        START = 1'b0;
        QP_IN = 6'd0;
    endtask

    task automatic run_to_done(input int limit);
        for (int t = 0; t < limit && n_fd == 0; t++) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        total++;
        if ({src_ready, NEWSLICE, NEWLINE, BUSY, FRAME_DONE} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {src_ready, NEWSLICE, NEWLINE, BUSY, FRAME_DONE});
        end
        total++;
        if ({intra4x4_STROBEI, intra8x8cc_strobei, QP} !== 8'b0) begin
            bad++;
            $display("FAIL reset_stb_qp got=%h want=00", {intra4x4_STROBEI, intra8x8cc_strobei, QP});
        end
        total++;
        if ({intra4x4_DATAI, intra8x8cc_datai, mb_x, mb_y} !== 80'b0) begin
            bad++;
            $display("FAIL reset_data_pos got=%h want=0", {intra4x4_DATAI, intra8x8cc_datai, mb_x, mb_y});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        auto_done = 1'b1; rand_valid = 1'b0; tog_mode = 1'b0;
        intra4x4_READYI = 1'b1;
        start_frame(6'd26);
        total++;
        if ({BUSY, NEWSLICE, NEWLINE, QP} !== {3'b111, 6'd26}) begin
            bad++;
            $display("FAIL start_state got=%b want=111011010", {BUSY, NEWSLICE, NEWLINE, QP});
        end
        repeat (50) tick();
        // START while busy must not disturb QP or the frame
        QP_IN = 6'd40;
        START = 1'b1;
        tick();
        START = 1'b0;
        QP_IN = 6'd0;
        run_to_done(3000);
        total++;
        if (n_fd !== 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", n_fd); end
        total++;
        if (n_luma !== 256) begin bad++; $display("FAIL luma_strobes got=%0d want=256", n_luma); end
        total++;
        if (n_chroma !== 128) begin bad++; $display("FAIL chroma_strobes got=%0d want=128", n_chroma); end
        total++;
        if (order_errs !== 0) begin bad++; $display("FAIL data_order got=%0d want=0", order_errs); end
        total++;
        if (stb_errs !== 0) begin bad++; $display("FAIL strobe_no_accept got=%0d want=0", stb_errs); end
        total++;
        if (ns_stb !== 1) begin bad++; $display("FAIL newslice_strobes got=%0d want=1", ns_stb); end
        total++;
        if (nl_stb !== 2) begin bad++; $display("FAIL newline_strobes got=%0d want=2", nl_stb); end
        total++;
        if (qp_errs !== 0) begin bad++; $display("FAIL qp_held got=%0d want=0", qp_errs); end
`ifdef H264SEQ_STATS_EN
        total++;
        if (frame_cycles !== 32'(fd_cyc - start_cyc + 1)) begin
            bad++;
            $display("FAIL frame_cycles got=%0d want=%0d", frame_cycles, fd_cyc - start_cyc + 1);
        end
`endif
        repeat (3) tick();
        total++;
        if ({BUSY, FRAME_DONE, src_ready} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_frame got=%b want=000", {BUSY, FRAME_DONE, src_ready});
        end
        total++;
        if (QP !== 6'd26) begin bad++; $display("FAIL qp_after_frame got=%0d want=26", QP); end
    endtask

    task automatic test_flow_control();
        auto_done = 1'b1; rand_valid = 1'b1; tog_mode = 1'b1;
        start_frame(6'd30);
        run_to_done(12000);
        tog_mode = 1'b0; rand_valid = 1'b0;
        intra4x4_READYI = 1'b1;
        total++;
        if (n_fd !== 1) begin bad++; $display("FAIL flow_frame_done got=%0d want=1", n_fd); end
        total++;
        if (n_luma !== 256) begin bad++; $display("FAIL flow_luma got=%0d want=256", n_luma); end
        total++;
        if (n_chroma !== 128) begin bad++; $display("FAIL flow_chroma got=%0d want=128", n_chroma); end
        total++;
        if (stb_errs !== 0) begin bad++; $display("FAIL flow_strobe_no_accept got=%0d want=0", stb_errs); end
        total++;
        if (order_errs !== 0) begin bad++; $display("FAIL flow_order got=%0d want=0", order_errs); end
        repeat (3) tick();
    endtask

    task automatic test_done_ignored_and_abort();
        auto_done = 1'b0;
        start_frame(6'd20);
        repeat (10) tick();
        xbuffer_DONE = 1'b1;
        tick();
        for (int t = 0; t < 500 && n_chroma < 32; t++) tick();
        repeat (8) tick();
        total++;
        if ({src_ready, BUSY, mb_x} !== {2'b01, 8'd0}) begin
            bad++;
            $display("FAIL wait_done_hold got=%b want=0100000000", {src_ready, BUSY, mb_x});
        end
        total++;
        if (n_luma !== 64) begin bad++; $display("FAIL wait_no_next_mb got=%0d want=64", n_luma); end
        xbuffer_DONE = 1'b1;
        tick();
        tick();
        total++;
        if ({mb_x, mb_y, NEWLINE} !== {8'd1, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL mb_advance got=x%0d y%0d nl%b want=x1 y0 nl0", mb_x, mb_y, NEWLINE);
        end
        for (int t = 0; t < 500 && n_luma < 94; t++) tick();
        RST = 1'b1;
        tick();
        total++;
        if ({src_ready, BUSY, FRAME_DONE, intra4x4_STROBEI, NEWSLICE, NEWLINE, QP, mb_x, mb_y}
            !== 28'b0) begin
            bad++;
            $display("FAIL abort_outputs got=%b want=0", {src_ready, BUSY, FRAME_DONE,
                     intra4x4_STROBEI, NEWSLICE, NEWLINE, QP, mb_x, mb_y});
        end
        RST = 1'b0;
        repeat (3) tick();
        total++;
        if (n_fd !== 0) begin bad++; $display("FAIL abort_no_frame_done got=%0d want=0", n_fd); end
        auto_done = 1'b1;
        start_frame(6'd26);
        total++;
        if ({NEWSLICE, mb_x, mb_y} !== {1'b1, 16'd0}) begin
            bad++;
            $display("FAIL restart_pos got=ns%b x%0d y%0d want=ns1 x0 y0", NEWSLICE, mb_x, mb_y);
        end
        run_to_done(3000);
        total++;
        if ({n_fd, n_luma, ns_stb} !== {32'd1, 32'd256, 32'd1}) begin
            bad++;
            $display("FAIL restart_frame got=fd%0d luma%0d ns%0d want=fd1 luma256 ns1",
                     n_fd, n_luma, ns_stb);
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; QP_IN = 6'd0;
        src_data = 32'd0; src_valid = 1'b1;
        intra4x4_READYI = 1'b1; intra8x8cc_readyi = 1'b1; xbuffer_DONE = 1'b0;
        auto_done = 1'b0; rand_valid = 1'b0; tog_mode = 1'b0;
        exp_word = 32'd0; exp_qp = 6'd0; prev_acc = 1'b0;
        n_luma = 0; n_chroma = 0; order_errs = 0; stb_errs = 0; qp_errs = 0;
        n_fd = 0; ns_stb = 0; nl_stb = 0; fd_cyc = 0; start_cyc = 0; done_dly = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_basic_frame();
        test_flow_control();
        test_done_ignored_and_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
